// File: rtl/bcd_time_keeper_pkg.sv
// Shared definitions for the BCD time keeper.
//   - BCD limit constants for hours, minutes/seconds and noon
//   - is_bcd():      both nibbles of a packed BCD byte are 0-9
//   - hh_24_to_12(): 24-hour BCD hour to 12-hour BCD display hour
package bcd_time_keeper_pkg;

  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX = 8'h59;
  localparam logic [7:0] BCD_NOON   = 8'h12;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Hour 00 shows as 12, 13-23 show as 01-11 and 01-12 pass through.
  function automatic logic [7:0] hh_24_to_12(input logic [7:0] hh);
    logic [4:0] w_bin;
    logic [4:0] w_h12;
    w_bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    if (w_bin == 5'd0) begin
      w_h12 = 5'd12;
    end else if (w_bin > 5'd12) begin
      w_h12 = w_bin - 5'd12;
    end else begin
      w_h12 = w_bin;
    end
    if (w_h12 >= 5'd10) begin
      return {4'd1, 4'(w_h12 - 5'd10)};
    end
    return {4'd0, 4'(w_h12)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed BCD counter that wraps MAX_VAL -> 00.
// Ports:
//   clk, reset   clock and synchronous active-high reset (clears to 00)
//   i_en         increment this cycle
//   i_load       load i_load_val (wins over i_en)
//   o_val        current count
//   o_next       count after this cycle's increment, ignoring load
//   o_carry      i_en high while the count is at MAX_VAL (wrap this cycle)
module bcd_mod_counter #(
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_val,
  output logic [7:0] o_next,
  output logic       o_carry
);

  logic [7:0] r_val;
  logic       w_at_max;

  assign w_at_max = (r_val == MAX_VAL);

  always_comb begin
    o_next = r_val;
    if (i_en) begin
      if (w_at_max) begin
        o_next = 8'h00;
      end else if (r_val[3:0] == 4'd9) begin
        o_next = {r_val[7:4] + 4'd1, 4'd0};
      end else begin
        o_next = {r_val[7:4], r_val[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_val <= 8'h00;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else begin
      r_val <= o_next;
    end
  end

  assign o_val   = r_val;
  assign o_carry = i_en && w_at_max;

endmodule

// File: rtl/bcd_time_keeper.sv
// Time-of-day keeper holding 24-hour packed BCD time with a 12/24-hour display.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ena                   prescaler count enable
//   mode_24               1: 24-hour display, 0: 12-hour display with pm flag
//   load, load_hh/mm/ss   one-cycle load request, 24-hour packed BCD
//   alarm_hh/mm, alarm_arm alarm time (24-hour BCD) and arm
//   hh, mm, ss, pm        displayed time
//   sec_tick, alarm       registered one-cycle pulses on advance / alarm match
//   load_err              registered one-cycle pulse on a rejected load
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter bit          ALARM_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode_24,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] r_presc;
  logic          r_sec_tick;
  logic          r_load_err;
  logic          w_load_ok;
  logic          w_load_acc;
  logic          w_adv;
  logic [7:0]    w_hh, w_mm, w_ss;
  logic [7:0]    w_hh_next, w_mm_next, w_ss_next;
  logic          w_ss_carry, w_mm_carry, w_hh_carry;
  logic          w_unused;

  assign w_load_ok = is_bcd(load_hh) && is_bcd(load_mm) && is_bcd(load_ss) &&
                     (load_hh <= BCD_HH_MAX) && (load_mm <= BCD_MS_MAX) &&
                     (load_ss <= BCD_MS_MAX);
  assign w_load_acc = load && w_load_ok;

  // Any load request, accepted or not, swallows a coincident advance.
  assign w_adv = ena && !load && (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_load_err <= load && !w_load_ok;
      if (load) begin
        if (w_load_ok) begin
          r_presc <= '0;
        end
      end else if (ena) begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      end
    end
  end

  bcd_mod_counter #(.MAX_VAL(BCD_MS_MAX)) u_ss (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_adv),
    .i_load     (w_load_acc),
    .i_load_val (load_ss),
    .o_val      (w_ss),
    .o_next     (w_ss_next),
    .o_carry    (w_ss_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_MS_MAX)) u_mm (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_ss_carry),
    .i_load     (w_load_acc),
    .i_load_val (load_mm),
    .o_val      (w_mm),
    .o_next     (w_mm_next),
    .o_carry    (w_mm_carry)
  );

  bcd_mod_counter #(.MAX_VAL(BCD_HH_MAX)) u_hh (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_mm_carry),
    .i_load     (w_load_acc),
    .i_load_val (load_hh),
    .o_val      (w_hh),
    .o_next     (w_hh_next),
    .o_carry    (w_hh_carry)
  );

  // Day wrap and the seconds next-value have no consumer here.
  assign w_unused = ^{w_hh_carry, w_ss_next};

  generate
    if (ALARM_EN) begin : g_alarm
      logic r_alarm;
      // Seconds carry means the advanced time lands on ss == 00.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_alarm <= 1'b0;
        end else begin
          r_alarm <= w_ss_carry && alarm_arm &&
                     (w_mm_next == alarm_mm) && (w_hh_next == alarm_hh);
        end
      end
      assign alarm = r_alarm;
    end else begin : g_no_alarm
      assign alarm = 1'b0;
    end
  endgenerate

  assign hh       = mode_24 ? w_hh : hh_24_to_12(w_hh);
  assign pm       = !mode_24 && (w_hh >= BCD_NOON);
  assign mm       = w_mm;
  assign ss       = w_ss;
  assign sec_tick = r_sec_tick;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_time_keeper.sv
module tb_bcd_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       mode_24 = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       alarm_arm = 1'b0;

  logic       pm1, tick1, alarm1, err1;
  logic [7:0] hh1, mm1, ss1;
  logic       pm4, tick4, alarm4, err4;
  logic [7:0] hh4, mm4, ss4;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds of day plus prescaler count per instance.
  int m_t   [2];
  int m_pc  [2];
  bit m_tick[2];
  bit m_alm [2];
  bit m_err [2];

  always #5 clk = ~clk;

  bcd_time_keeper #(.TICKS_PER_SEC(1), .ALARM_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ena(ena), .mode_24(mode_24), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .pm(pm1), .hh(hh1), .mm(mm1), .ss(ss1),
    .sec_tick(tick1), .alarm(alarm1), .load_err(err1)
  );

  bcd_time_keeper #(.TICKS_PER_SEC(4), .ALARM_EN(1'b1)) dut4 (
    .clk(clk), .reset(reset), .ena(ena), .mode_24(mode_24), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .pm(pm4), .hh(hh4), .mm(mm4), .ss(ss4),
    .sec_tick(tick4), .alarm(alarm4), .load_err(err4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] b;
    b = {4'(n / 10), 4'(n % 10)};
    return b;
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (int'(v[7:4]) * 10 + int'(v[3:0]) <= lim);
  endfunction

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int tps;
      tps = (k == 0) ? 1 : 4;
      m_tick[k] = 1'b0;
      m_alm[k]  = 1'b0;
      m_err[k]  = 1'b0;
      if (reset) begin
        m_t[k]  = 0;
        m_pc[k] = 0;
      end else if (load) begin
        if (bcd_ok(load_hh, 23) && bcd_ok(load_mm, 59) && bcd_ok(load_ss, 59)) begin
          m_t[k]  = from_bcd(load_hh) * 3600 + from_bcd(load_mm) * 60 + from_bcd(load_ss);
          m_pc[k] = 0;
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (ena) begin
        m_pc[k]++;
        if (m_pc[k] == tps) begin
          m_pc[k]   = 0;
          m_t[k]    = (m_t[k] + 1) % 86400;
          m_tick[k] = 1'b1;
          m_alm[k]  = alarm_arm && (m_t[k] % 60 == 0) &&
                      (to_bcd(m_t[k] / 3600) == alarm_hh) &&
                      (to_bcd((m_t[k] / 60) % 60) == alarm_mm);
        end
      end
    end
  endtask

  function automatic logic [24:0] exp_time(input int k);
    int h, hd;
    h  = m_t[k] / 3600;
    hd = mode_24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    return {to_bcd(hd), to_bcd((m_t[k] / 60) % 60), to_bcd(m_t[k] % 60),
            (!mode_24 && h >= 12)};
  endfunction

  task automatic compare_all();
    check_eq("dut1_time", {7'd0, hh1, mm1, ss1, pm1}, {7'd0, exp_time(0)});
    check_eq("dut1_pulse", {29'd0, tick1, alarm1, err1}, {29'd0, m_tick[0], m_alm[0], m_err[0]});
    check_eq("dut4_time", {7'd0, hh4, mm4, ss4, pm4}, {7'd0, exp_time(1)});
    check_eq("dut4_pulse", {29'd0, tick4, alarm4, err4}, {29'd0, m_tick[1], m_alm[1], m_err[1]});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic en);
    load_hh = h; load_mm = m; load_ss = s; load = 1'b1; ena = en;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    // Reset, 12-hour display.
    reset = 1'b1; ena = 1'b1; load = 1'b1; load_hh = 8'h05;
    cycle();
    cycle();
    reset = 1'b0; load = 1'b0; ena = 1'b0;
    check_eq("rst_hh12", {24'd0, hh1}, 32'h12);
    check_eq("rst_mmss", {16'd0, mm1, ss1}, 32'h0000);
    check_eq("rst_pm", {31'd0, pm1}, 32'd0);
    check_eq("rst_pulses", {29'd0, tick1, alarm1, err1}, 32'd0);
    mode_24 = 1'b1;
    #1;
    check_eq("rst_hh24", {24'd0, hh1}, 32'h00);
    compare_all();
    mode_24 = 1'b0;
    #1;

    // One hour of advances at one tick per second.
    ena = 1'b1;
    for (int i = 0; i < 3600; i++) begin
      cycle();
      check_eq("tick_every", {31'd0, tick1}, 32'd1);
    end
    check_eq("hour_time", {7'd0, hh1, mm1, ss1, pm1}, {7'd0, 8'h01, 8'h00, 8'h00, 1'b0});

    // Noon and midnight rollovers.
    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    ena = 1'b1;
    cycle();
    check_eq("noon_time", {7'd0, hh1, mm1, ss1, pm1}, {7'd0, 8'h12, 8'h00, 8'h00, 1'b1});
    do_load(8'h23, 8'h59, 8'h59, 1'b0);
    ena = 1'b1;
    cycle();
    check_eq("midn_time", {7'd0, hh1, mm1, ss1, pm1}, {7'd0, 8'h12, 8'h00, 8'h00, 1'b0});
    mode_24 = 1'b1;
    #1;
    check_eq("midn_hh24", {24'd0, hh1}, 32'h00);
    compare_all();

    // Rejected loads leave the time alone.
    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    check_eq("rej24_err", {31'd0, err1}, 32'd1);
    check_eq("rej24_time", {8'd0, hh1, mm1, ss1}, 32'h000000);
    do_load(8'h1A, 8'h00, 8'h00, 1'b0);
    check_eq("rej1a_err", {31'd0, err1}, 32'd1);
    check_eq("rej1a_time", {8'd0, hh1, mm1, ss1}, 32'h000000);
    ena = 1'b0;
    cycle();
    check_eq("err_once", {31'd0, err1}, 32'd0);

    // Load wins over a coincident advance.
    do_load(8'h13, 8'h45, 8'h00, 1'b1);
    check_eq("ldpri_time", {8'd0, hh1, mm1, ss1}, 32'h134500);
    check_eq("ldpri_tick", {31'd0, tick1}, 32'd0);
    mode_24 = 1'b0;

    // Alarm armed, then disarmed.
    alarm_hh = 8'h07; alarm_mm = 8'h30;
    for (int pass = 0; pass < 2; pass++) begin
      alarm_arm = (pass == 0);
      do_load(8'h07, 8'h29, 8'h58, 1'b0);
      check_eq("alm_load", {31'd0, alarm1}, 32'd0);
      ena = 1'b1;
      cycle();
      check_eq("alm_pre", {31'd0, alarm1}, 32'd0);
      cycle();
      check_eq("alm_hit", {31'd0, alarm1}, (pass == 0) ? 32'd1 : 32'd0);
      cycle();
      check_eq("alm_once", {31'd0, alarm1}, 32'd0);
    end
    alarm_arm = 1'b0;

    // Prescaler of four with gapped enable, then reset mid-phase.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ena = (i != 1);
      cycle();
      check_eq("p4_gap_tick", {31'd0, tick4}, (i == 4) ? 32'd1 : 32'd0);
    end
    ena = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("p4_rst_tick", {31'd0, tick4}, (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("p4_rst_ss", {24'd0, ss4}, 32'h01);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      ena     = ($urandom_range(0, 3) != 0);
      mode_24 = $urandom_range(0, 1);
      load    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 0) begin
        load_hh = to_bcd($urandom_range(0, 23));
        load_mm = to_bcd($urandom_range(0, 59));
        load_ss = to_bcd($urandom_range(0, 59));
      end else begin
        load_hh = 8'($urandom);
        load_mm = 8'($urandom);
        load_ss = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) begin
        int nt;
        nt = (m_t[$urandom_range(0, 1)] + 60) % 86400;
        alarm_hh = to_bcd(nt / 3600);
        alarm_mm = to_bcd((nt / 60) % 60);
      end
      alarm_arm = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
